// File: rtl/open_mips_min_sopc_pkg.sv
// Shared encodings for the minimal MIPS32 SoC: opcode/funct fields, ALU operation
// and result-select codes, the nop word and the stage-register payloads.
`timescale 1ns/1ps
package open_mips_min_sopc_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [DATA_W-1:0] NOP_INST = 32'h0;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LUI     = 6'b001111;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_JALR = 6'b001001;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MTHI = 6'b010001;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [5:0] FN_MTLO = 6'b010011;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_DIVU = 6'b011011;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;

   typedef enum logic [3:0] {
      ALU_NOP, ALU_OR, ALU_AND, ALU_XOR, ALU_NOR, ALU_ADDU, ALU_SUBU, ALU_SLL,
      ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO, ALU_DIV, ALU_DIVU, ALU_LINK
   } alu_op_t;

   typedef enum logic [2:0] {
      SEL_NOP, SEL_LOGIC, SEL_ARITH, SEL_SHIFT, SEL_MOVE, SEL_LINK
   } alu_sel_t;

   typedef struct packed {
      alu_op_t                 alu_op;
      alu_sel_t                alu_sel;
      logic [DATA_W-1:0]       reg1;
      logic [DATA_W-1:0]       reg2;
      logic [REG_ADDR_W-1:0]   wd;
      logic                    wreg;
      logic [DATA_W-1:0]       link_addr;
   } id_ex_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0]   wd;
      logic                    wreg;
      logic [DATA_W-1:0]       wdata;
      logic                    whilo;
      logic [DATA_W-1:0]       hi;
      logic [DATA_W-1:0]       lo;
   } wb_t;

endpackage

// File: rtl/open_mips_min_sopc_openmips.sv
// Five-stage MIPS32 core: fetch pc, IF/ID decode with jump resolution and operand
// forwarding, single-cycle EX (including divide), pass-through MEM, and WB into regfile/HI-LO.
`timescale 1ns/1ps
module regfile
   import open_mips_min_sopc_pkg::*;
(
   input  logic                  clk,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0]     rdata1,
   output logic [DATA_W-1:0]     rdata2
);
   logic [DATA_W-1:0] regs [0:31];

   always_ff @(posedge clk) begin
      if (we && waddr != '0)
         regs[waddr] <= wdata;
   end

   // A write in WB is visible to a same-cycle read in ID.
   always_comb begin
      rdata1 = regs[raddr1];
      rdata2 = regs[raddr2];
      if (we && waddr == raddr1) rdata1 = wdata;
      if (we && waddr == raddr2) rdata2 = wdata;
      if (raddr1 == '0) rdata1 = '0;
      if (raddr2 == '0) rdata2 = '0;
   end
endmodule

module hilo_reg
   import open_mips_min_sopc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] hi,
   input  logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_o <= '0;
         lo_o <= '0;
      end else if (we) begin
         hi_o <= hi;
         lo_o <= lo;
      end
   end
endmodule

module openmips
   import open_mips_min_sopc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] rom_addr,
   output logic              rom_ce
);
   logic [DATA_W-1:0] pc, id_pc, id_inst, delay_pc;
   logic              ce, jump;
   logic [DATA_W-1:0] jump_target;
   logic [DATA_W-1:0] rs_data, rt_data, rs_val, rt_val;
   logic [DATA_W-1:0] hi, lo, hi_fwd, lo_fwd;
   logic [DATA_W-1:0] squo, srem;
   logic signed [DATA_W-1:0] sdividend, sdivisor;
   logic [5:0]        op, funct;
   logic [4:0]        rs, rt, rd, sa;
   logic [15:0]       imm;
   id_ex_t            id_ctrl, ex_ctrl;
   wb_t               ex_res, mem_res, wb_res;

   assign rom_addr = pc;
   assign rom_ce   = ce;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce <= 1'b0;
         pc <= '0;
      end else begin
         ce <= 1'b1;
         if (!ce)       pc <= '0;
         else if (jump) pc <= jump_target;
         else           pc <= pc + 32'd4;
      end
   end

   assign op       = id_inst[31:26];
   assign rs       = id_inst[25:21];
   assign rt       = id_inst[20:16];
   assign rd       = id_inst[15:11];
   assign sa       = id_inst[10:6];
   assign funct    = id_inst[5:0];
   assign imm      = id_inst[15:0];
   assign delay_pc = id_pc + 32'd4;

   regfile regfile1 (
      .clk(clk), .we(wb_res.wreg), .waddr(wb_res.wd), .wdata(wb_res.wdata),
      .raddr1(rs), .raddr2(rt), .rdata1(rs_data), .rdata2(rt_data)
   );

   // EX result is newer than MEM, so it wins; r0 never matches since wreg is dropped for it.
   always_comb begin
      rs_val = rs_data;
      rt_val = rt_data;
      if (ex_res.wreg && ex_res.wd == rs)        rs_val = ex_res.wdata;
      else if (mem_res.wreg && mem_res.wd == rs) rs_val = mem_res.wdata;
      if (ex_res.wreg && ex_res.wd == rt)        rt_val = ex_res.wdata;
      else if (mem_res.wreg && mem_res.wd == rt) rt_val = mem_res.wdata;
   end

   always_comb begin
      id_ctrl           = '0;
      jump              = 1'b0;
      jump_target       = '0;
      id_ctrl.reg1      = rs_val;
      id_ctrl.reg2      = rt_val;
      id_ctrl.wd        = rd;
      id_ctrl.link_addr = delay_pc + 32'd4;
      case (op)
         OP_SPECIAL: begin
            case (funct)
               FN_OR:   begin id_ctrl.alu_op = ALU_OR;   id_ctrl.alu_sel = SEL_LOGIC; id_ctrl.wreg = 1'b1; end
               FN_AND:  begin id_ctrl.alu_op = ALU_AND;  id_ctrl.alu_sel = SEL_LOGIC; id_ctrl.wreg = 1'b1; end
               FN_XOR:  begin id_ctrl.alu_op = ALU_XOR;  id_ctrl.alu_sel = SEL_LOGIC; id_ctrl.wreg = 1'b1; end
               FN_NOR:  begin id_ctrl.alu_op = ALU_NOR;  id_ctrl.alu_sel = SEL_LOGIC; id_ctrl.wreg = 1'b1; end
               FN_ADDU: begin id_ctrl.alu_op = ALU_ADDU; id_ctrl.alu_sel = SEL_ARITH; id_ctrl.wreg = 1'b1; end
               FN_SUBU: begin id_ctrl.alu_op = ALU_SUBU; id_ctrl.alu_sel = SEL_ARITH; id_ctrl.wreg = 1'b1; end
               FN_SLL: begin
                  id_ctrl.alu_op  = ALU_SLL;
                  id_ctrl.alu_sel = SEL_SHIFT;
                  id_ctrl.reg1    = {27'b0, sa};
                  id_ctrl.wreg    = 1'b1;
               end
               FN_JR: begin
                  jump        = 1'b1;
                  jump_target = rs_val;
               end
               FN_JALR: begin
                  jump            = 1'b1;
                  jump_target     = rs_val;
                  id_ctrl.alu_op  = ALU_LINK;
                  id_ctrl.alu_sel = SEL_LINK;
                  id_ctrl.wreg    = 1'b1;
               end
               FN_MFHI: begin id_ctrl.alu_op = ALU_MFHI; id_ctrl.alu_sel = SEL_MOVE; id_ctrl.wreg = 1'b1; end
               FN_MFLO: begin id_ctrl.alu_op = ALU_MFLO; id_ctrl.alu_sel = SEL_MOVE; id_ctrl.wreg = 1'b1; end
               FN_MTHI: id_ctrl.alu_op = ALU_MTHI;
               FN_MTLO: id_ctrl.alu_op = ALU_MTLO;
               FN_DIV:  id_ctrl.alu_op = ALU_DIV;
               FN_DIVU: id_ctrl.alu_op = ALU_DIVU;
               default: ;
            endcase
         end
         OP_ORI: begin
            id_ctrl.alu_op  = ALU_OR;
            id_ctrl.alu_sel = SEL_LOGIC;
            id_ctrl.reg2    = {16'b0, imm};
            id_ctrl.wd      = rt;
            id_ctrl.wreg    = 1'b1;
         end
         OP_LUI: begin
            id_ctrl.alu_op  = ALU_OR;
            id_ctrl.alu_sel = SEL_LOGIC;
            id_ctrl.reg1    = '0;
            id_ctrl.reg2    = {imm, 16'b0};
            id_ctrl.wd      = rt;
            id_ctrl.wreg    = 1'b1;
         end
         OP_J: begin
            jump        = 1'b1;
            jump_target = {delay_pc[31:28], id_inst[25:0], 2'b00};
         end
         OP_JAL: begin
            jump            = 1'b1;
            jump_target     = {delay_pc[31:28], id_inst[25:0], 2'b00};
            id_ctrl.alu_op  = ALU_LINK;
            id_ctrl.alu_sel = SEL_LINK;
            id_ctrl.wd      = 5'd31;
            id_ctrl.wreg    = 1'b1;
         end
         default: ;
      endcase
      if (id_ctrl.wd == '0) id_ctrl.wreg = 1'b0;
   end

   // mfhi/mflo and partial HI/LO writes see the newest pending value: MEM first, then WB.
   always_comb begin
      hi_fwd = hi;
      lo_fwd = lo;
      if (mem_res.whilo) begin
         hi_fwd = mem_res.hi;
         lo_fwd = mem_res.lo;
      end else if (wb_res.whilo) begin
         hi_fwd = wb_res.hi;
         lo_fwd = wb_res.lo;
      end
   end

   assign sdividend = ex_ctrl.reg1;
   assign sdivisor  = ex_ctrl.reg2;
   assign squo      = sdividend / sdivisor;
   assign srem      = sdividend % sdivisor;

   always_comb begin
      ex_res      = '0;
      ex_res.wd   = ex_ctrl.wd;
      ex_res.wreg = ex_ctrl.wreg;
      ex_res.hi   = hi_fwd;
      ex_res.lo   = lo_fwd;
      case (ex_ctrl.alu_sel)
         SEL_LOGIC: begin
            case (ex_ctrl.alu_op)
               ALU_OR:  ex_res.wdata = ex_ctrl.reg1 | ex_ctrl.reg2;
               ALU_AND: ex_res.wdata = ex_ctrl.reg1 & ex_ctrl.reg2;
               ALU_XOR: ex_res.wdata = ex_ctrl.reg1 ^ ex_ctrl.reg2;
               ALU_NOR: ex_res.wdata = ~(ex_ctrl.reg1 | ex_ctrl.reg2);
               default: ex_res.wdata = '0;
            endcase
         end
         SEL_ARITH: ex_res.wdata = (ex_ctrl.alu_op == ALU_SUBU) ? ex_ctrl.reg1 - ex_ctrl.reg2
                                                                : ex_ctrl.reg1 + ex_ctrl.reg2;
         SEL_SHIFT: ex_res.wdata = ex_ctrl.reg2 << ex_ctrl.reg1[4:0];
         SEL_MOVE:  ex_res.wdata = (ex_ctrl.alu_op == ALU_MFHI) ? hi_fwd : lo_fwd;
         SEL_LINK:  ex_res.wdata = ex_ctrl.link_addr;
         default:   ex_res.wdata = '0;
      endcase
      case (ex_ctrl.alu_op)
         ALU_MTHI: begin ex_res.whilo = 1'b1; ex_res.hi = ex_ctrl.reg1; end
         ALU_MTLO: begin ex_res.whilo = 1'b1; ex_res.lo = ex_ctrl.reg1; end
         ALU_DIV: begin
            if (ex_ctrl.reg2 != '0) begin
               ex_res.whilo = 1'b1;
               ex_res.hi    = srem;
               ex_res.lo    = squo;
            end
         end
         ALU_DIVU: begin
            if (ex_ctrl.reg2 != '0) begin
               ex_res.whilo = 1'b1;
               ex_res.hi    = ex_ctrl.reg1 % ex_ctrl.reg2;
               ex_res.lo    = ex_ctrl.reg1 / ex_ctrl.reg2;
            end
         end
         default: ;
      endcase
   end

   // No stalls or flushes: every stage register advances each cycle and clears to nop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc   <= '0;
         id_inst <= NOP_INST;
         ex_ctrl <= '0;
         mem_res <= '0;
         wb_res  <= '0;
      end else begin
         id_pc   <= pc;
         id_inst <= rom_data;
         ex_ctrl <= id_ctrl;
         mem_res <= ex_res;
         wb_res  <= mem_res;
      end
   end

   hilo_reg hilo_reg0 (
      .clk(clk), .rst(rst), .we(wb_res.whilo), .hi(wb_res.hi), .lo(wb_res.lo),
      .hi_o(hi), .lo_o(lo)
   );
endmodule

// File: rtl/open_mips_min_sopc.sv
// Minimal SoC: the openmips core fetching from a combinational, word-addressed
// instruction ROM whose contents are preloaded from outside the design.
`timescale 1ns/1ps
module inst_rom #(
   parameter int DEPTH = 1024
) (
   input  logic        ce,
   input  logic [31:0] addr,
   output logic [31:0] inst
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0] inst_mem [0:DEPTH-1];
   logic        unused_addr;

   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
   assign inst        = ce ? inst_mem[addr[AW+1:2]] : 32'h0;
endmodule

module open_mips_min_sopc
   import open_mips_min_sopc_pkg::*;
#(
   parameter int INST_MEM_DEPTH = 1024
) (
   input logic clk,
   input logic rst
);
   logic [DATA_W-1:0] rom_addr, rom_data;
   logic              rom_ce;

   openmips openmips0 (
      .clk(clk), .rst(rst), .rom_data(rom_data), .rom_addr(rom_addr), .rom_ce(rom_ce)
   );

   inst_rom #(.DEPTH(INST_MEM_DEPTH)) inst_rom0 (
      .ce(rom_ce), .addr(rom_addr), .inst(rom_data)
   );
endmodule

// File: tb/tb_open_mips_min_sopc.sv
// Scoreboard bench for open_mips_min_sopc: loads a jump/div program into the ROM and
// checks timed register and HI/LO results against expectations queued with the program.
`timescale 1ns/1ps
module tb_open_mips_min_sopc;

   logic clk;
   logic rst;

   typedef struct {
      int          t;
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   numAssertions = 0;
   int   numFailures   = 0;

   open_mips_min_sopc dut (.clk(clk), .rst(rst));

   initial begin
      clk = 1'b0;
      forever #1 clk = ~clk;
   end

   initial begin
      rst = 1'b1;
      #20 rst = 1'b0;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numAssertions++;
      if (observed !== expected) begin
         numFailures++;
         $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", tag, $time, observed, expected);
      end
   endtask

   function automatic logic [31:0] sample(input int sel);
      case (sel)
         0:       return dut.openmips0.regfile1.regs[1];
         1:       return dut.openmips0.regfile1.regs[31];
         2:       return dut.openmips0.hilo_reg0.hi_o;
         3:       return dut.openmips0.hilo_reg0.lo_o;
         4:       return dut.openmips0.regfile1.regs[2];
         5:       return dut.openmips0.pc;
         default: return {31'b0, dut.openmips0.ce};
      endcase
   endfunction

   task automatic expectAt(input int t, input string tag, input int sel, input logic [31:0] val);
      exp_t e;
      e.t   = t;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < 1024; i++) dut.inst_rom0.inst_mem[i] = 32'h0;
      dut.inst_rom0.inst_mem[0]  = 32'h34010001; // ori  $1,$0,1
      dut.inst_rom0.inst_mem[1]  = 32'h08000008; // j    0x20
      dut.inst_rom0.inst_mem[2]  = 32'h34010002; // ori  $1,$0,2    (slot)
      dut.inst_rom0.inst_mem[3]  = 32'h34011111; // ori  $1,$0,0x1111 (skipped)
      dut.inst_rom0.inst_mem[8]  = 32'h34010003; // ori  $1,$0,3
      dut.inst_rom0.inst_mem[9]  = 32'h0C000010; // jal  0x40
      dut.inst_rom0.inst_mem[10] = 32'h03E1001A; // div  $31,$1     (slot)
      dut.inst_rom0.inst_mem[11] = 32'h34010005; // ori  $1,$0,5
      dut.inst_rom0.inst_mem[12] = 32'h34010006; // ori  $1,$0,6
      dut.inst_rom0.inst_mem[13] = 32'h20010077; // addi (unsupported -> nop)
      dut.inst_rom0.inst_mem[14] = 32'h08000018; // j    0x60
      dut.inst_rom0.inst_mem[15] = 32'h34010007; // ori  $1,$0,7    (slot)
      dut.inst_rom0.inst_mem[16] = 32'h03E01009; // jalr $2,$31
      dut.inst_rom0.inst_mem[17] = 32'h00400825; // or   $1,$2,$0   (slot)
      dut.inst_rom0.inst_mem[18] = 32'h34010009; // ori  $1,$0,9
      dut.inst_rom0.inst_mem[19] = 32'h3401000A; // ori  $1,$0,0xA
      dut.inst_rom0.inst_mem[20] = 32'h08000014; // j    0x50 (loop)
      dut.inst_rom0.inst_mem[24] = 32'h00400008; // jr   $2
      dut.inst_rom0.inst_mem[25] = 32'h34010008; // ori  $1,$0,8    (slot)

      expectAt(10, "reset_pc",        5, 32'h0);
      expectAt(10, "reset_ce",        6, 32'h0);
      expectAt(10, "reset_hi",        2, 32'h0);
      expectAt(10, "reset_lo",        3, 32'h0);
      expectAt(22, "ce_after_reset",  6, 32'h1);
      expectAt(22, "pc_first_fetch",  5, 32'h0);
      expectAt(24, "pc_increment",    5, 32'h4);
      expectAt(32, "ori_first",       0, 32'h1);
      expectAt(34, "j_no_write",      0, 32'h1);
      expectAt(36, "j_delay_slot",    0, 32'h2);
      expectAt(38, "j_target",        0, 32'h3);
      expectAt(40, "jal_link",        1, 32'h2C);
      expectAt(40, "hi_before_div",   2, 32'h0);
      expectAt(42, "div_hi",          2, 32'h2);
      expectAt(42, "div_lo",          3, 32'hE);
      expectAt(44, "jalr_link",       4, 32'h48);
      expectAt(44, "r1_after_div",    0, 32'h3);
      expectAt(46, "jalr_slot_fwd",   0, 32'h48);
      expectAt(48, "return_ori5",     0, 32'h5);
      expectAt(50, "return_ori6",     0, 32'h6);
      expectAt(52, "unsupported_nop", 0, 32'h6);
      expectAt(54, "j60_no_write",    0, 32'h6);
      expectAt(56, "j60_slot",        0, 32'h7);
      expectAt(58, "jr_no_write",     0, 32'h7);
      expectAt(60, "jr_slot",         0, 32'h8);
      expectAt(62, "jr_target",       0, 32'h9);
      expectAt(64, "final_ori",       0, 32'hA);
      expectAt(64, "hi_stable",       2, 32'h2);
      expectAt(64, "lo_stable",       3, 32'hE);
      expectAt(70, "loop_r1",         0, 32'hA);
      expectAt(70, "loop_r2",         4, 32'h48);
   endtask

   initial begin
      exp_t e;
      int   now;
      applyStimulus();
      for (int cyc = 0; cyc < 36; cyc++) begin
         @(negedge clk);
         now = int'($time);
         while (exp_q.size() > 0 && exp_q[0].t == now) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, sample(e.sel), e.val);
         end
         if (now >= 32)
            checkOutput("skipped_ori_never_seen", {31'b0, sample(0) == 32'h1111}, 32'h0);
      end
      checkOutput("scoreboard_drained", exp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", numAssertions, numFailures);
      $finish;
   end

endmodule
